string_word_feeder: RTL and testbench
=====================================

# string_word_feeder

Upstream feeder for the string hardware accelerator core. It accepts a NUL-terminated character stream one byte per handshake and packs it into 4-character words. It presents each word and its valid-character count to the core over the core's level `go` / `done` handshake, and frames the string with a last-word flag. It also truncates over-long strings and reports truncation and character count to software-visible status.

## Interface
- `MAX_LEN`, default 64: maximum non-NUL characters per string; legal range 1..65535.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state and outputs immediately.
- `char_in`  in  8: input character; 0x00 is the terminator.
- `char_valid`  in  1: `char_in` is valid this cycle.
- `char_ready`  out  1: feeder accepts `char_in`; a transfer happens when `char_valid && char_ready` at the clock edge.
- `str_word`  out  32: packed word; character 0 in [31:24], character 3 in [7:0]; unused lanes are 0x00.
- `str_len`  out  3: valid characters in `str_word`, 0..4.
- `str_last`  out  1: `str_word` is the final word of the string.
- `go`  out  1: request to core; held high until `done` is seen.
- `done`  in  1: core completion for the current word.
- `str_end`  out  1: one-cycle pulse when the last word's handshake completes.
- `char_count`  out  16: non-NUL characters accepted for the current or most recent string.
- `str_overflow`  out  1: the current or most recent string was truncated at `MAX_LEN`.

## Operation
- States: FILL, BUSY, DRAIN, DISCARD. Reset state is FILL.
- Reset values:
  - `char_ready`=1.
  - `go`, `str_last`, `str_end`, `str_overflow`=0.
  - `str_word`=0, `str_len`=0, `char_count`=0.
  - Lane counter=0.
- FILL: `char_ready`=1. On each accepted byte:
  - Non-NUL: write the byte to lane `lane_cnt` and increment `lane_cnt` and `char_count`.
    - If the lane counter reaches 4: word complete, `str_len`=4, `str_last`=0, go to BUSY.
    - Else if `char_count` reaches `MAX_LEN`: word complete with the current fill, `str_last`=1, `str_overflow`=1, go to BUSY, with DISCARD pending.
  - NUL: word complete, `str_len`=lane count (0..3), `str_last`=1, go to BUSY. The NUL itself is not stored.
- First byte of a new string (the first accepted byte after `str_end`, or after reset): clears `char_count` and `str_overflow` before counting that byte.
- BUSY:
  - `char_ready`=0 and `go`=1.
  - `str_word`, `str_len`, `str_last` are stable.
  - On `done`=1 go to DRAIN.
- DRAIN:
  - `go`=0 and `char_ready`=0.
  - Wait for `done`=0.
  - Then clear the lane buffer to 0x00000000 and the lane counter to 0.
  - If the word was last: pulse `str_end`, then go to DISCARD if truncated, otherwise FILL.
  - If not last: go to FILL.
- DISCARD:
  - `char_ready`=1; every accepted byte is dropped.
  - A NUL byte returns the block to FILL.
  - `char_count` and `str_overflow` hold.
- A string whose length is a multiple of 4 produces a trailing `str_len`=0, `str_last`=1 word.
- The empty string (a lone NUL) produces a single len-0 last word.
- `done` is ignored in FILL and DISCARD, whether stale or spurious.
- `char_count` saturates at `MAX_LEN`; it never wraps.

## Timing
- A byte accepted at edge N that completes a word gives `go`=1 and `char_ready`=0 from edge N (registered outputs, visible in cycle N+1).
- `done` sampled high at edge M drops `go` in cycle M+1.
- `done` sampled low at edge K (in DRAIN) gives `char_ready`=1 in cycle K+1 and `str_end` high for exactly cycle K+1 when the word was last.
- Minimum word turnaround is 4 FILL cycles + 1 BUSY + 1 DRAIN, with a zero-latency core.
- `go` never rises while `done` is still high from the previous word (guaranteed by DRAIN).
- Reset asserted mid-BUSY drops `go` asynchronously, without waiting for a clock edge; the in-flight word is discarded.

## Structure
- Shared package `string_hw_pkg`:
  - `feeder_state_t` enum (FILL, BUSY, DRAIN, DISCARD).
  - `CHAR_NUL`=8'h00.
  - `WORD_BYTES`=4.
  - `word_t` as a `[0:3][7:0]` packed type, so `str_word` maps lane i to char i.
- One sub-module is natural: `string_lane_packer`. It holds the lane buffer, lane counter, lane-write decode and clear. The FSM, counters and handshake stay in the top.

## Test plan
- Send "ABCDEFG\0" with `done` returned 2 cycles after `go`. Required: word 0x41424344 with len 4, last 0; then word 0x45464700 with len 3, last 1; one `str_end` pulse; `char_count`=7.
- Send "WXYZ\0". Required: 0x5758595A len 4 last 0, then 0x00000000 len 0 last 1; a lone "\0" gives a single len-0 last word.
- With `MAX_LEN`=6, send "ABCDEFGH\0". Required: 0x41424344 len 4 last 0, then 0x45460000 len 2 last 1, `str_overflow`=1, `char_count`=6. "GH\0" is consumed with no `go`; the next string clears the overflow flag.
- Hold `done` high for 5 cycles after `go` drops. Required: `char_ready` stays 0 and no new `go` until `done`=0.
- Assert reset mid-BUSY. Required: `go`=0 immediately, outputs at reset values; the next string packs from lane 0.
- Pulse `done` while in FILL; send `char_valid` in BUSY. Required: no state change and no byte accepted.

Source files
------------

// File: rtl/string_hw_pkg.sv
// Shared types and constants for the string accelerator front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package string_hw_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        BUSY    = 2'd1,
        DRAIN   = 2'd2,
        DISCARD = 2'd3
    } feeder_state_t;

    localparam logic [7:0] CHAR_NUL   = 8'h00;
    localparam int         WORD_BYTES = 4;

    // Lane i occupies the i-th byte from the top, so char 0 lands in [31:24].
    typedef logic [0:WORD_BYTES-1][7:0] word_t;

endpackage

// File: rtl/string_lane_packer.sv
// Lane buffer: writes one byte per strobe into the next lane, cleared between words.
// Latency: written byte visible in the word on the cycle after the strobe.
// Backpressure: none; the owner gates i_wr so at most four writes occur per word.
module string_lane_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr,
    input  logic        i_clr,
    input  logic [7:0]  i_dat,
    output logic [31:0] o_word,
    output logic [2:0]  o_lane_cnt
);
    import string_hw_pkg::*;

    word_t      r_word;
    logic [2:0] r_lane_cnt;

    // Clear wins over write; a write drops the byte into the current lane and advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_lane_cnt <= 3'd0;
        end else if (i_clr) begin
            r_word     <= '0;
            r_lane_cnt <= 3'd0;
        end else if (i_wr) begin
            r_word[r_lane_cnt[1:0]] <= i_dat;
            r_lane_cnt              <= r_lane_cnt + 3'd1;
        end
    end

    assign o_word     = r_word;
    assign o_lane_cnt = r_lane_cnt;

endmodule

// File: rtl/string_word_feeder.sv
// Packs a NUL-terminated byte stream into 4-char words and hands them to the core via go/done.
// Latency: word presented (go=1) the cycle after its completing byte; 1 DRAIN cycle after done falls.
// Backpressure: char_ready low from word completion until done has risen and fallen again.
module string_word_feeder #(
    parameter int MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [31:0] str_word,
    output logic [2:0]  str_len,
    output logic        str_last,
    output logic        go,
    input  logic        done,
    output logic        str_end,
    output logic [15:0] char_count,
    output logic        str_overflow
);
    import string_hw_pkg::*;

    localparam logic [15:0] MAX_C = 16'(MAX_LEN);

    feeder_state_t r_state;
    logic          r_char_ready;
    logic          r_go;
    logic [2:0]    r_str_len;
    logic          r_str_last;
    logic          r_str_end;
    logic [15:0]   r_char_count;
    logic          r_overflow;
    logic          r_discard_pend;
    logic          r_new_str;

    logic          w_accept;
    logic          w_is_nul;
    logic          w_at_max;
    logic          w_pk_wr;
    logic          w_pk_clr;
    logic [15:0]   w_cnt_base;
    logic [15:0]   w_cnt_next;
    logic [2:0]    w_lane_cnt;
    logic [31:0]   w_word;

    assign w_accept   = char_valid && r_char_ready;
    assign w_is_nul   = (char_in == CHAR_NUL);
    // The first byte of a new string counts from zero rather than the previous total.
    assign w_cnt_base = r_new_str ? 16'd0 : r_char_count;
    assign w_cnt_next = w_cnt_base + 16'd1;
    // Already holding MAX_LEN chars (only reachable when the limit fell on a word boundary).
    assign w_at_max   = (w_cnt_base >= MAX_C);
    assign w_pk_wr    = (r_state == FILL) && w_accept && !w_is_nul && !w_at_max;
    assign w_pk_clr   = (r_state == DRAIN) && !done;

    string_lane_packer u_packer (
        .clk        (clk),
        .rst        (reset),
        .i_wr       (w_pk_wr),
        .i_clr      (w_pk_clr),
        .i_dat      (char_in),
        .o_word     (w_word),
        .o_lane_cnt (w_lane_cnt)
    );

    // Feeder FSM: fill lanes, hold the word for the core, wait out done, skip truncated tails.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= FILL;
            r_char_ready   <= 1'b1;
            r_go           <= 1'b0;
            r_str_len      <= 3'd0;
            r_str_last     <= 1'b0;
            r_str_end      <= 1'b0;
            r_char_count   <= 16'd0;
            r_overflow     <= 1'b0;
            r_discard_pend <= 1'b0;
            r_new_str      <= 1'b1;
        end else begin
            r_str_end <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_new_str <= 1'b0;
                        if (r_new_str) begin
                            r_overflow <= 1'b0;
                        end
                        if (w_is_nul) begin
                            r_char_count <= w_cnt_base;
                            r_str_len    <= w_lane_cnt;
                            r_str_last   <= 1'b1;
                            r_go         <= 1'b1;
                            r_char_ready <= 1'b0;
                            r_state      <= BUSY;
                        end else if (w_at_max) begin
                            // Limit hit exactly at a word boundary: drop this byte, close with an empty word.
                            r_char_count   <= w_cnt_base;
                            r_str_len      <= w_lane_cnt;
                            r_str_last     <= 1'b1;
                            r_overflow     <= 1'b1;
                            r_discard_pend <= 1'b1;
                            r_go           <= 1'b1;
                            r_char_ready   <= 1'b0;
                            r_state        <= BUSY;
                        end else begin
                            r_char_count <= w_cnt_next;
                            if (w_lane_cnt == 3'd3) begin
                                r_str_len    <= 3'd4;
                                r_str_last   <= 1'b0;
                                r_go         <= 1'b1;
                                r_char_ready <= 1'b0;
                                r_state      <= BUSY;
                            end else if (w_cnt_next == MAX_C) begin
                                r_str_len      <= w_lane_cnt + 3'd1;
                                r_str_last     <= 1'b1;
                                r_overflow     <= 1'b1;
                                r_discard_pend <= 1'b1;
                                r_go           <= 1'b1;
                                r_char_ready   <= 1'b0;
                                r_state        <= BUSY;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (done) begin
                        r_go    <= 1'b0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!done) begin
                        r_char_ready <= 1'b1;
                        if (r_str_last) begin
                            r_str_end      <= 1'b1;
                            r_new_str      <= 1'b1;
                            r_discard_pend <= 1'b0;
                            r_state        <= r_discard_pend ? DISCARD : FILL;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                DISCARD: begin
                    if (w_accept && w_is_nul) begin
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign char_ready   = r_char_ready;
    assign go           = r_go;
    assign str_word     = w_word;
    assign str_len      = r_str_len;
    assign str_last     = r_str_last;
    assign str_end      = r_str_end;
    assign char_count   = r_char_count;
    assign str_overflow = r_overflow;

endmodule

// File: tb/tb_string_word_feeder.sv
// Bench for string_word_feeder: default instance plus a MAX_LEN=6 instance, scoreboarded words.
// Latency: n/a.
// Backpressure: bench core model raises done a configurable number of cycles after go.
module tb_string_word_feeder;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  len;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_in [2];
    logic        char_valid [2];
    logic        char_ready [2];
    logic [31:0] str_word [2];
    logic [2:0]  str_len [2];
    logic        str_last [2];
    logic        go [2];
    logic        done [2];
    logic        str_end [2];
    logic [15:0] char_count [2];
    logic        str_overflow [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ends [2];
    bit   auto_on [2];
    int   dly [2];

    always #5 clk = ~clk;

    string_word_feeder u_dut (
        .clk(clk), .reset(reset), .char_in(char_in[0]), .char_valid(char_valid[0]),
        .char_ready(char_ready[0]), .str_word(str_word[0]), .str_len(str_len[0]),
        .str_last(str_last[0]), .go(go[0]), .done(done[0]), .str_end(str_end[0]),
        .char_count(char_count[0]), .str_overflow(str_overflow[0])
    );

    string_word_feeder #(.MAX_LEN(6)) u_dut6 (
        .clk(clk), .reset(reset), .char_in(char_in[1]), .char_valid(char_valid[1]),
        .char_ready(char_ready[1]), .str_word(str_word[1]), .str_len(str_len[1]),
        .str_last(str_last[1]), .go(go[1]), .done(done[1]), .str_end(str_end[1]),
        .char_count(char_count[1]), .str_overflow(str_overflow[1])
    );

    task automatic push(input int i, input logic [31:0] w, input logic [2:0] len, input logic last);
        exp_t e;
        e.w = w; e.len = len; e.last = last;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Reference packing for strings under MAX_LEN: full 4-char words, then a last word with the rest.
    task automatic push_model(input int i, input string s);
        logic [31:0] w;
        int n;
        n = s.len();
        w = '0;
        for (int k = 0; k < n; k++) begin
            w = w | ({24'd0, s[k]} << (8 * (3 - (k % 4))));
            if (k % 4 == 3) begin
                push(i, w, 3'd4, 1'b0);
                w = '0;
            end
        end
        push(i, w, 3'(n % 4), 1'b1);
    endtask

    // Word monitor: every rising go pops one expected word; also counts str_end cycles.
    task automatic monitor();
        logic pg [2];
        exp_t e;
        pg[0] = 1'b0; pg[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (str_end[i]) ends[i]++;
                if (go[i] && !pg[i]) begin
                    n_chk++;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        $display("FAIL word_sb[%0d]: go with no word expected, got word=%h len=%0d last=%0d", i, str_word[i], str_len[i], str_last[i]);
                    end else begin
                        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                        if ({str_word[i], str_len[i], str_last[i]} !== {e.w, e.len, e.last})
                            $display("FAIL word_sb[%0d]: got word=%h len=%0d last=%0d, want word=%h len=%0d last=%0d", i, str_word[i], str_len[i], str_last[i], e.w, e.len, e.last);
                        else n_pass++;
                    end
                end
                pg[i] = go[i];
            end
        end
    endtask

    // Core model: raise done dly cycles after go, drop it once go has fallen.
    task automatic responder();
        int wc [2];
        wc[0] = 0; wc[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (auto_on[i]) begin
                    if (go[i] && !done[i]) begin
                        wc[i]++;
                        if (wc[i] >= dly[i]) begin
                            done[i] = 1'b1;
                            wc[i] = 0;
                        end
                    end else if (done[i] && !go[i]) begin
                        done[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic put_byte(input int i, input logic [7:0] c, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        char_in[i] = c;
        char_valid[i] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (char_ready[i]) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_str(input int i, input string s);
        bit ok;
        logic [7:0] c;
        for (int k = 0; k <= s.len(); k++) begin
            c = (k == s.len()) ? 8'h00 : s[k];
            put_byte(i, c, ok);
            if (!ok) begin
                n_chk++;
                $display("FAIL send[%0d]: byte %0d of \"%s\" not accepted within 200 cycles", i, k, s);
                break;
            end
        end
        @(negedge clk);
        char_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!go[i] && !done[i] && char_ready[i] && ((i == 0) ? q0.size() : q1.size()) == 0) begin
                idle = 1'b1;
                break;
            end
        end
        @(negedge clk);
        n_chk++;
        if (!idle) $display("FAIL idle[%0d]: feeder not idle after 300 cycles, got go=%0d ready=%0d, want go=0 ready=1", i, go[i], char_ready[i]);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({char_ready[i], go[i], str_last[i], str_end[i], str_overflow[i]} !== 5'b10000)
                $display("FAIL reset_flags[%0d]: got rdy/go/last/end/ovf=%b, want 10000", i, {char_ready[i], go[i], str_last[i], str_end[i], str_overflow[i]});
            else n_pass++;
            n_chk++;
            if ({str_word[i], str_len[i], char_count[i]} !== 51'd0)
                $display("FAIL reset_data[%0d]: got word=%h len=%0d cnt=%0d, want all 0", i, str_word[i], str_len[i], char_count[i]);
            else n_pass++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e0;
        e0 = ends[0];
        auto_on[0] = 1'b1; dly[0] = 2;
        push(0, 32'h41424344, 3'd4, 1'b0);
        push(0, 32'h45464700, 3'd3, 1'b1);
        send_str(0, "ABCDEFG");
        wait_idle(0);
        n_chk++;
        if (ends[0] - e0 !== 1) $display("FAIL basic_end: got %0d str_end cycles, want 1", ends[0] - e0); else n_pass++;
        n_chk++;
        if (char_count[0] !== 16'd7 || str_overflow[0] !== 1'b0)
            $display("FAIL basic_count: got cnt=%0d ovf=%0d, want cnt=7 ovf=0", char_count[0], str_overflow[0]);
        else n_pass++;
    endtask

    task automatic test_mult4();
        int e0;
        e0 = ends[0];
        push(0, 32'h5758595A, 3'd4, 1'b0);
        push(0, 32'h00000000, 3'd0, 1'b1);
        send_str(0, "WXYZ");
        wait_idle(0);
        n_chk++;
        if (char_count[0] !== 16'd4) $display("FAIL mult4_count: got %0d, want 4", char_count[0]); else n_pass++;
        push(0, 32'h00000000, 3'd0, 1'b1);
        send_str(0, "");
        wait_idle(0);
        n_chk++;
        if (char_count[0] !== 16'd0) $display("FAIL empty_count: got %0d, want 0", char_count[0]); else n_pass++;
        n_chk++;
        if (ends[0] - e0 !== 2) $display("FAIL mult4_end: got %0d str_end cycles, want 2", ends[0] - e0); else n_pass++;
    endtask

    task automatic test_overflow();
        auto_on[1] = 1'b1; dly[1] = 1;
        push(1, 32'h41424344, 3'd4, 1'b0);
        push(1, 32'h45460000, 3'd2, 1'b1);
        send_str(1, "ABCDEFGH");
        wait_idle(1);
        n_chk++;
        if (char_count[1] !== 16'd6 || str_overflow[1] !== 1'b1)
            $display("FAIL ovf_flag: got cnt=%0d ovf=%0d, want cnt=6 ovf=1", char_count[1], str_overflow[1]);
        else n_pass++;
        push(1, 32'h48490000, 3'd2, 1'b1);
        send_str(1, "HI");
        wait_idle(1);
        n_chk++;
        if (char_count[1] !== 16'd2 || str_overflow[1] !== 1'b0)
            $display("FAIL ovf_clear: got cnt=%0d ovf=%0d, want cnt=2 ovf=0", char_count[1], str_overflow[1]);
        else n_pass++;
    endtask

    task automatic test_done_hold();
        bit ok;
        bit bad;
        string s;
        s = "ABCD";
        auto_on[0] = 1'b0;
        push(0, 32'h41424344, 3'd4, 1'b0);
        for (int k = 0; k < 4; k++) put_byte(0, s[k], ok);
        @(negedge clk);
        char_valid[0] = 1'b0;
        n_chk++;
        if (go[0] !== 1'b1 || char_ready[0] !== 1'b0)
            $display("FAIL hold_go: got go=%0d ready=%0d after 4th byte, want go=1 ready=0", go[0], char_ready[0]);
        else n_pass++;
        done[0] = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (go[0] !== 1'b0 || char_ready[0] !== 1'b0) bad = 1'b1;
        end
        n_chk++;
        if (bad) $display("FAIL hold_done: go/ready moved while done held, got go=%0d ready=%0d, want 0 0", go[0], char_ready[0]);
        else n_pass++;
        done[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (char_ready[0] !== 1'b1 || go[0] !== 1'b0)
            $display("FAIL hold_release: got ready=%0d go=%0d, want ready=1 go=0", char_ready[0], go[0]);
        else n_pass++;
        auto_on[0] = 1'b1;
        push(0, 32'h00000000, 3'd0, 1'b1);
        send_str(0, "");
        wait_idle(0);
        n_chk++;
        if (char_count[0] !== 16'd4) $display("FAIL hold_count: got %0d, want 4", char_count[0]); else n_pass++;
    endtask

    task automatic test_reset_busy();
        bit ok;
        string s;
        s = "PQRS";
        auto_on[0] = 1'b0;
        push(0, 32'h50515253, 3'd4, 1'b0);
        for (int k = 0; k < 4; k++) put_byte(0, s[k], ok);
        @(negedge clk);
        char_valid[0] = 1'b0;
        n_chk++;
        if (go[0] !== 1'b1) $display("FAIL rstbusy_go: got go=%0d before reset, want 1", go[0]); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (go[0] !== 1'b0 || char_ready[0] !== 1'b1 || str_word[0] !== 32'd0 || str_len[0] !== 3'd0 || char_count[0] !== 16'd0)
            $display("FAIL rstbusy_async: got go=%0d rdy=%0d word=%h len=%0d cnt=%0d, want 0 1 0 0 0", go[0], char_ready[0], str_word[0], str_len[0], char_count[0]);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        auto_on[0] = 1'b1; dly[0] = 1;
        push(0, 32'h4B4C0000, 3'd2, 1'b1);
        send_str(0, "KL");
        wait_idle(0);
        n_chk++;
        if (char_count[0] !== 16'd2) $display("FAIL rstbusy_count: got %0d, want 2", char_count[0]); else n_pass++;
    endtask

    task automatic test_spurious();
        bit ok;
        bit bad;
        string s;
        s = "MNOP";
        auto_on[0] = 1'b0;
        @(negedge clk);
        done[0] = 1'b1;
        repeat (2) @(negedge clk);
        done[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (char_ready[0] !== 1'b1 || go[0] !== 1'b0 || str_word[0] !== 32'd0 || char_count[0] !== 16'd2)
            $display("FAIL spur_done: got rdy=%0d go=%0d word=%h cnt=%0d, want 1 0 0 2", char_ready[0], go[0], str_word[0], char_count[0]);
        else n_pass++;
        push(0, 32'h4D4E4F50, 3'd4, 1'b0);
        for (int k = 0; k < 4; k++) put_byte(0, s[k], ok);
        @(negedge clk);
        char_in[0] = 8'h5A;
        char_valid[0] = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (char_ready[0] !== 1'b0 || str_word[0] !== 32'h4D4E4F50) bad = 1'b1;
        end
        char_valid[0] = 1'b0;
        n_chk++;
        if (bad) $display("FAIL spur_busy: byte taken in BUSY, got rdy=%0d word=%h, want 0 4d4e4f50", char_ready[0], str_word[0]);
        else n_pass++;
        auto_on[0] = 1'b1;
        push(0, 32'h00000000, 3'd0, 1'b1);
        send_str(0, "");
        wait_idle(0);
        n_chk++;
        if (char_count[0] !== 16'd4) $display("FAIL spur_count: got %0d, want 4", char_count[0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        string s;
        int n;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 10);
            s = "";
            for (int k = 0; k < n; k++) s = {s, string'(8'($urandom_range(33, 126)))};
            dly[0] = $urandom_range(1, 3);
            push_model(0, s);
            send_str(0, s);
            wait_idle(0);
            n_chk++;
            if (char_count[0] !== 16'(n)) $display("FAIL b2b_count[%0d]: got %0d, want %0d", r, char_count[0], n);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            char_in[i] = 8'h00; char_valid[i] = 1'b0; done[i] = 1'b0;
            ends[i] = 0; auto_on[i] = 1'b0; dly[i] = 1;
        end
        fork
            monitor();
            responder();
        join_none
        test_reset();
        test_basic();
        test_mult4();
        test_overflow();
        test_done_hold();
        test_reset_busy();
        test_spurious();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
